// File: rtl/mole_game_engine.sv
// Whack-a-mole game engine: raises MAX_ACTIVE moles per wave and scores key hits in packed BCD.
// Optional build macro MOLE_PENALTY_EN: a miss also subtracts one point, saturating at zero.
module mole_game_engine #(
    parameter int HOLES       = 16,
    parameter int MAX_ACTIVE  = 2,
    parameter int UP_TICKS    = 50_000_000,
    parameter int ROUND_WAVES = 30,
    parameter int DIGITS      = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4:0]          keyvalue,
    input  logic                keyfinish,
    input  logic [3:0]          rnd,
    output logic [HOLES-1:0]    mole_mask,
    output logic [1:0]          state,
    output logic [4*DIGITS-1:0] score,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic                game_over
);
    localparam int IDX_W  = $clog2(HOLES);
    localparam int CNT_W  = $clog2(MAX_ACTIVE + 1);
    localparam int TMR_W  = $clog2(UP_TICKS + 1);
    localparam int WAVE_W = $clog2(ROUND_WAVES + 1);
    localparam logic [TMR_W-1:0] UP_LOAD = TMR_W'(UP_TICKS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPAWN = 2'd1;
    localparam logic [1:0] S_UP    = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_reg, state_next;
    logic [HOLES-1:0]    mask_reg, mask_next;
    logic [4*DIGITS-1:0] score_reg, score_next;
    logic [TMR_W-1:0]    timer_reg, timer_next;
    logic [WAVE_W-1:0]   wave_reg, wave_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                hit_reg, miss_reg;

    logic [IDX_W-1:0]    key_idx, spawn_idx;
    logic [HOLES-1:0]    key_onehot, spawn_onehot, mask_after_hit;
    logic [WAVE_W:0]     wave_inc;
    logic                key_valid, in_up, hit, miss, wave_end, last_wave;
    logic                restart, spawn_new, spawn_full;

    assign key_idx        = keyvalue[IDX_W-1:0];
    assign spawn_idx      = rnd[IDX_W-1:0];
    assign key_onehot     = HOLES'(1) << key_idx;
    assign spawn_onehot   = HOLES'(1) << spawn_idx;
    assign key_valid      = keyfinish && (keyvalue < 5'(HOLES));
    assign in_up          = (state_reg == S_UP);
    assign hit            = in_up && key_valid && |(mask_reg & key_onehot);
    assign miss           = in_up && key_valid && !hit;
    assign mask_after_hit = hit ? (mask_reg & ~key_onehot) : mask_reg;
    // A hit on the last raised mole ends the wave in the same cycle as the hit.
    assign wave_end       = in_up && ((timer_reg == '0) || (mask_after_hit == '0));
    assign wave_inc       = {1'b0, wave_reg} + (WAVE_W+1)'(1);
    assign last_wave      = wave_inc >= (WAVE_W+1)'(ROUND_WAVES);
    assign restart        = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign spawn_new      = (state_reg == S_SPAWN) && !(|(mask_reg & spawn_onehot));
    assign spawn_full     = spawn_new && (cnt_reg == CNT_W'(MAX_ACTIVE - 1));

    // Per-digit BCD increment/decrement; carries and borrows come from the lower digits.
    logic [DIGITS-1:0]   is_nine;
    logic [4*DIGITS-1:0] score_inc;
    logic                all_nines;
`ifdef MOLE_PENALTY_EN
    logic [DIGITS-1:0]   is_zero;
    logic [4*DIGITS-1:0] score_dec;
    logic                all_zero;
    assign all_zero = &is_zero;
`endif
    assign all_nines = &is_nine;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] dig;
            logic       inc_en;
            assign dig         = score_reg[4*gi +: 4];
            assign is_nine[gi] = (dig == 4'd9);
            if (gi == 0) begin : g_lsd_inc
                assign inc_en = 1'b1;
            end else begin : g_up_inc
                assign inc_en = &is_nine[gi-1:0];
            end
            assign score_inc[4*gi +: 4] = !inc_en ? dig : (is_nine[gi] ? 4'd0 : dig + 4'd1);
`ifdef MOLE_PENALTY_EN
            logic dec_en;
            assign is_zero[gi] = (dig == 4'd0);
            if (gi == 0) begin : g_lsd_dec
                assign dec_en = 1'b1;
            end else begin : g_up_dec
                assign dec_en = &is_zero[gi-1:0];
            end
            assign score_dec[4*gi +: 4] = !dec_en ? dig : (is_zero[gi] ? 4'd9 : dig - 4'd1);
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SPAWN;
            S_SPAWN: if (spawn_full) state_next = S_UP;
            S_UP:    if (wave_end) state_next = last_wave ? S_DONE : S_SPAWN;
            default: if (start) state_next = S_SPAWN;
        endcase
    end

    always_comb begin
        state     = state_reg;
        game_over = (state_reg == S_DONE);
    end

    always_comb begin
        mask_next  = mask_reg;
        score_next = score_reg;
        timer_next = timer_reg;
        wave_next  = wave_reg;
        cnt_next   = cnt_reg;
        if (restart) begin
            mask_next  = '0;
            score_next = '0;
            wave_next  = '0;
            cnt_next   = '0;
        end else if (state_reg == S_SPAWN) begin
            if (spawn_new) begin
                mask_next = mask_reg | spawn_onehot;
                cnt_next  = cnt_reg + CNT_W'(1);
            end
            if (spawn_full) timer_next = UP_LOAD;
        end else if (in_up) begin
            mask_next = mask_after_hit;
            if (timer_reg != '0) timer_next = timer_reg - TMR_W'(1);
            if (hit) score_next = all_nines ? score_reg : score_inc;
`ifdef MOLE_PENALTY_EN
            else if (miss) score_next = all_zero ? score_reg : score_dec;
`endif
            if (wave_end) begin
                mask_next = '0;
                wave_next = wave_inc[WAVE_W-1:0];
                cnt_next  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg  <= '0;
            score_reg <= '0;
            timer_reg <= '0;
            wave_reg  <= '0;
            cnt_reg   <= '0;
            hit_reg   <= 1'b0;
            miss_reg  <= 1'b0;
        end else begin
            mask_reg  <= mask_next;
            score_reg <= score_next;
            timer_reg <= timer_next;
            wave_reg  <= wave_next;
            cnt_reg   <= cnt_next;
            hit_reg   <= hit;
            miss_reg  <= miss;
        end
    end

    assign mole_mask  = mask_reg;
    assign score      = score_reg;
    assign hit_pulse  = hit_reg;
    assign miss_pulse = miss_reg;
endmodule

// File: tb/tb_mole_game_engine.sv
// Scoreboard bench: a short two-wave game on one instance, a long game for BCD saturation on another.
module tb_mole_game_engine;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPAWN = 2'd1;
    localparam logic [1:0] S_UP    = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
`ifdef MOLE_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v  [2];
    logic       kf_v     [2];
    logic [4:0] kv_v     [2];
    logic [3:0] rnd_v    [2];
    logic [3:0] mask_v   [2];
    logic [1:0] state_v  [2];
    logic [7:0] score_v  [2];
    logic       hit_v    [2];
    logic       miss_v   [2];
    logic       go_v     [2];

    int checks = 0;
    int errors = 0;
    int exp_score [2];
    string       tag_q [$];
    logic [31:0] val_q [$];

    always #5 clk = ~clk;

    mole_game_engine #(.HOLES(4), .MAX_ACTIVE(2), .UP_TICKS(8), .ROUND_WAVES(2), .DIGITS(2)) u_short (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .keyvalue(kv_v[0]), .keyfinish(kf_v[0]),
        .rnd(rnd_v[0]), .mole_mask(mask_v[0]), .state(state_v[0]), .score(score_v[0]),
        .hit_pulse(hit_v[0]), .miss_pulse(miss_v[0]), .game_over(go_v[0]));

    mole_game_engine #(.HOLES(4), .MAX_ACTIVE(2), .UP_TICKS(8), .ROUND_WAVES(64), .DIGITS(2)) u_long (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .keyvalue(kv_v[1]), .keyfinish(kf_v[1]),
        .rnd(rnd_v[1]), .mole_mask(mask_v[1]), .state(state_v[1]), .score(score_v[1]),
        .hit_pulse(hit_v[1]), .miss_pulse(miss_v[1]), .game_over(go_v[1]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    function automatic logic [31:0] observe(input int d);
        return {15'd0, hit_v[d], miss_v[d], go_v[d], state_v[d], mask_v[d], score_v[d]};
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] tens, ones;
        tens = 4'(n / 10);
        ones = 4'(n % 10);
        return {tens, ones};
    endfunction

    task automatic pop_check(input logic [31:0] obs);
        if (val_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            check_val(tag_q.pop_front(), obs, val_q.pop_front());
        end
    endtask

    // One clock of stimulus on instance d; the model score follows the expected hit/miss.
    task automatic step(input int d, input string tag, input logic s, input logic kf,
                        input logic [4:0] kv, input logic [3:0] r, input logic [1:0] es,
                        input logic [3:0] em, input logic eh, input logic emiss);
        start_v[d] = s;
        kf_v[d]    = kf;
        kv_v[d]    = kv;
        rnd_v[d]   = r;
        if (eh) exp_score[d] = (exp_score[d] < 99) ? exp_score[d] + 1 : 99;
        if (emiss && PEN) exp_score[d] = (exp_score[d] > 0) ? exp_score[d] - 1 : 0;
        tag_q.push_back(tag);
        val_q.push_back({15'd0, eh, emiss, (es == S_DONE), es, em, to_bcd(exp_score[d])});
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        kf_v[d]    = 1'b0;
        kv_v[d]    = 5'd0;
        pop_check(observe(d));
    endtask

    initial begin
        int waves;
        bit missed;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; kf_v[d] = 1'b0; kv_v[d] = 5'd0; rnd_v[d] = 4'd0; exp_score[d] = 0;
        end
        #2;
        check_val("reset_short", observe(0), 32'd0);
        check_val("reset_long", observe(1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Spawn with rnd 1,1,3, then two hits clear the wave early.
        step(0, "start",        1, 0, 5'd0,  4'd0, S_SPAWN, 4'b0000, 0, 0);
        step(0, "spawn_r1",     0, 0, 5'd0,  4'd1, S_SPAWN, 4'b0010, 0, 0);
        step(0, "spawn_r1_dup", 0, 0, 5'd0,  4'd1, S_SPAWN, 4'b0010, 0, 0);
        step(0, "spawn_r3_up",  0, 0, 5'd0,  4'd3, S_UP,    4'b1010, 0, 0);
        step(0, "hit_k1",       0, 1, 5'd1,  4'd0, S_UP,    4'b1000, 1, 0);
        step(0, "hit_k3_end",   0, 1, 5'd3,  4'd0, S_SPAWN, 4'b0000, 1, 0);
        check_val("score_two", {24'd0, score_v[0]}, 32'h02);
        // Second wave times out after 8 UP cycles and ends the game.
        step(0, "w2_r0",        0, 0, 5'd0,  4'd0, S_SPAWN, 4'b0001, 0, 0);
        step(0, "w2_r2_up",     0, 0, 5'd0,  4'd2, S_UP,    4'b0101, 0, 0);
        step(0, "miss_k1",      0, 1, 5'd1,  4'd0, S_UP,    4'b0101, 0, 1);
        step(0, "key20_ignored",0, 1, 5'd20, 4'd0, S_UP,    4'b0101, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, "up_wait",  0, 0, 5'd0,  4'd0, S_UP,    4'b0101, 0, 0);
        step(0, "timeout_done", 0, 0, 5'd0,  4'd0, S_DONE,  4'b0000, 0, 0);
        step(0, "key_in_done",  0, 1, 5'd0,  4'd0, S_DONE,  4'b0000, 0, 0);
        exp_score[0] = 0;
        step(0, "restart",      1, 0, 5'd0,  4'd0, S_SPAWN, 4'b0000, 0, 0);
        step(0, "r2",           0, 0, 5'd0,  4'd2, S_SPAWN, 4'b0100, 0, 0);
        step(0, "start_in_spawn",1,0, 5'd0,  4'd2, S_SPAWN, 4'b0100, 0, 0);
        step(0, "r3_up",        0, 0, 5'd0,  4'd3, S_UP,    4'b1100, 0, 0);
        step(0, "start_in_up",  1, 0, 5'd0,  4'd0, S_UP,    4'b1100, 0, 0);
        // Asynchronous reset in the middle of a clock period.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset", observe(0), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        exp_score[0] = 0;
        step(0, "post_reset_idle", 0, 0, 5'd0, 4'd0, S_IDLE, 4'b0000, 0, 0);

        // Long game: hit coinciding with timer expiry, miss at 10, then saturation at 99.
        exp_score[1] = 0;
        step(1, "L_start",      1, 0, 5'd0, 4'd0, S_SPAWN, 4'b0000, 0, 0);
        step(1, "L_r0",         0, 0, 5'd0, 4'd0, S_SPAWN, 4'b0001, 0, 0);
        step(1, "L_r1_up",      0, 0, 5'd0, 4'd1, S_UP,    4'b0011, 0, 0);
        step(1, "L_hit_early",  0, 1, 5'd0, 4'd0, S_UP,    4'b0010, 1, 0);
        for (int i = 0; i < 6; i++)
            step(1, "L_wait",   0, 0, 5'd0, 4'd0, S_UP,    4'b0010, 0, 0);
        step(1, "L_hit_expiry", 0, 1, 5'd1, 4'd0, S_SPAWN, 4'b0000, 1, 0);
        waves = 0;
        missed = 1'b0;
        while (exp_score[1] < 99 && waves < 60) begin
            step(1, "L_r0",     0, 0, 5'd0, 4'd0, S_SPAWN, 4'b0001, 0, 0);
            step(1, "L_r1_up",  0, 0, 5'd0, 4'd1, S_UP,    4'b0011, 0, 0);
            if (exp_score[1] == 10 && !missed) begin
                step(1, "L_miss_at_10", 0, 1, 5'd2, 4'd0, S_UP, 4'b0011, 0, 1);
                check_val("L_miss_score", {24'd0, score_v[1]}, PEN ? 32'h09 : 32'h10);
                missed = 1'b1;
            end
            step(1, "L_hit0",   0, 1, 5'd0, 4'd0, S_UP,    4'b0010, 1, 0);
            step(1, "L_hit1",   0, 1, 5'd1, 4'd0, S_SPAWN, 4'b0000, 1, 0);
            waves++;
        end
        check_val("L_wave_budget", {31'd0, (waves < 60)}, 32'd1);
        check_val("L_miss_seen", {31'd0, missed}, 32'd1);
        step(1, "L_sat_r0",     0, 0, 5'd0, 4'd0, S_SPAWN, 4'b0001, 0, 0);
        step(1, "L_sat_r1_up",  0, 0, 5'd0, 4'd1, S_UP,    4'b0011, 0, 0);
        step(1, "L_sat_hit0",   0, 1, 5'd0, 4'd0, S_UP,    4'b0010, 1, 0);
        step(1, "L_sat_hit1",   0, 1, 5'd1, 4'd0, S_SPAWN, 4'b0000, 1, 0);
        check_val("L_score_sat", {24'd0, score_v[1]}, 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
